// File: rtl/gshare_bht.sv
// gshare branch predictor: a flat PHT indexed by slot PC XOR a hash of the speculative GHR.
// Define GSHARE_HIST_FOLD_EN to XOR-fold histories longer than the index width into the hash.
module gshare_bht #(
    parameter int unsigned VLEN            = 39,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned HIST_LEN        = 10,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned OFFSET          = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic [HIST_LEN-1:0]        pred_hist_o,
    input  logic                       spec_valid_i,
    input  logic                       spec_taken_i,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    input  logic [HIST_LEN-1:0]        upd_hist_i,
    input  logic                       upd_taken_i,
    input  logic                       upd_mispredict_i
);
    localparam int unsigned IDX_BITS = $clog2(NR_ENTRIES);
    localparam logic [VLEN-1:0] SLOT_MASK = VLEN'(INSTR_PER_FETCH - 1) << OFFSET;

    // History bit b lands on index bit b mod IDX_BITS; without folding only the low bits count.
    function automatic logic [IDX_BITS-1:0] hash_hist(input logic [HIST_LEN-1:0] g);
        logic [IDX_BITS-1:0] h;
        h = '0;
        for (int b = 0; b < int'(HIST_LEN); b++) begin
`ifdef GSHARE_HIST_FOLD_EN
            h[b % IDX_BITS] = h[b % IDX_BITS] ^ g[b];
`else
            if (b < int'(IDX_BITS)) h[b % IDX_BITS] = g[b];
`endif
        end
        return h;
    endfunction

    logic [NR_ENTRIES-1:0] valid_reg;
    logic [1:0]            ctr_reg [NR_ENTRIES];
    logic [HIST_LEN-1:0]   ghr_reg, ghr_next;
    logic [HIST_LEN-1:0]   ghr_recover, ghr_shift;
    logic [IDX_BITS-1:0]   ghr_hash, upd_idx;
    logic                  train_en;
    logic [1:0]            ctr_old, ctr_new;
    logic                  unused_bits;

    assign ghr_hash = hash_hist(ghr_reg);
    assign upd_idx  = upd_pc_i[OFFSET +: IDX_BITS] ^ hash_hist(upd_hist_i);
    assign train_en = upd_valid_i && !debug_mode_i && !flush_i;
    assign ctr_old  = ctr_reg[upd_idx];

    always_comb begin
        ctr_new = ctr_old;
        if (upd_taken_i && ctr_old != 2'b11)
            ctr_new = ctr_old + 2'b01;
        else if (!upd_taken_i && ctr_old != 2'b00)
            ctr_new = ctr_old - 2'b01;
    end

    // Flush must clear every entry in one cycle, so the table lives in flops rather than RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= '0;
            for (int e = 0; e < int'(NR_ENTRIES); e++) ctr_reg[e] <= 2'b01;
        end else if (flush_i) begin
            valid_reg <= '0;
            for (int e = 0; e < int'(NR_ENTRIES); e++) ctr_reg[e] <= 2'b01;
        end else if (train_en) begin
            valid_reg[upd_idx] <= 1'b1;
            ctr_reg[upd_idx]   <= ctr_new;
        end
    end

    if (HIST_LEN == 1) begin : g_hist_one
        assign ghr_recover = upd_taken_i;
        assign ghr_shift   = spec_taken_i;
    end else begin : g_hist_wide
        assign ghr_recover = {upd_hist_i[HIST_LEN-2:0], upd_taken_i};
        assign ghr_shift   = {ghr_reg[HIST_LEN-2:0], spec_taken_i};
    end

    // Recovery from a mispredict beats speculation and is honoured even in debug mode.
    always_comb begin
        ghr_next = ghr_reg;
        if (flush_i)
            ghr_next = '0;
        else if (upd_valid_i && upd_mispredict_i)
            ghr_next = ghr_recover;
        else if (spec_valid_i && !debug_mode_i)
            ghr_next = ghr_shift;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ghr_reg <= '0;
        else         ghr_reg <= ghr_next;
    end

    for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot
        logic [VLEN-1:0]     slot_pc;
        logic [IDX_BITS-1:0] slot_idx;
        assign slot_pc          = (vpc_i & ~SLOT_MASK) | (VLEN'(gi) << OFFSET);
        assign slot_idx         = slot_pc[OFFSET +: IDX_BITS] ^ ghr_hash;
        assign pred_valid_o[gi] = valid_reg[slot_idx];
        assign pred_taken_o[gi] = ctr_reg[slot_idx][1];
    end

    assign pred_hist_o = ghr_reg;
    assign unused_bits = ^{vpc_i, upd_pc_i, upd_hist_i};
endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht: default build instance plus a 16-bit-history/256-entry instance.
module tb_gshare_bht;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_ni = 1'b1;
    logic zero_bit = 1'b0;

    logic        flush, debug, spec_valid, spec_taken;
    logic        upd_valid, upd_taken, upd_mis;
    logic [38:0] vpc, upd_pc;
    logic [9:0]  upd_hist;
    logic [1:0]  pv, pt;
    logic [9:0]  ph;

    logic        b_upd_valid, b_upd_taken, b_upd_mis;
    logic [38:0] b_vpc, b_upd_pc;
    logic [15:0] b_upd_hist;
    logic [1:0]  b_pv, b_pt;
    logic [15:0] b_ph;

    gshare_bht dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush), .debug_mode_i(debug),
        .vpc_i(vpc), .pred_valid_o(pv), .pred_taken_o(pt), .pred_hist_o(ph),
        .spec_valid_i(spec_valid), .spec_taken_i(spec_taken),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist),
        .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mis)
    );

    gshare_bht #(.VLEN(39), .NR_ENTRIES(256), .HIST_LEN(16), .INSTR_PER_FETCH(2), .OFFSET(1)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(zero_bit), .debug_mode_i(zero_bit),
        .vpc_i(b_vpc), .pred_valid_o(b_pv), .pred_taken_o(b_pt), .pred_hist_o(b_ph),
        .spec_valid_i(zero_bit), .spec_taken_i(zero_bit),
        .upd_valid_i(b_upd_valid), .upd_pc_i(b_upd_pc), .upd_hist_i(b_upd_hist),
        .upd_taken_i(b_upd_taken), .upd_mispredict_i(b_upd_mis)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [38:0] pc, input logic [9:0] hist, input logic taken, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_hist = hist; upd_taken = taken; upd_mis = mis;
        @(posedge clk_i); #1;
        upd_valid = 1'b0; upd_mis = 1'b0;
    endtask

    task automatic spec(input logic taken);
        spec_valid = 1'b1; spec_taken = taken;
        @(posedge clk_i); #1;
        spec_valid = 1'b0;
    endtask

    task automatic b_upd(input logic [38:0] pc, input logic [15:0] hist, input logic taken, input logic mis);
        b_upd_valid = 1'b1; b_upd_pc = pc; b_upd_hist = hist; b_upd_taken = taken; b_upd_mis = mis;
        @(posedge clk_i); #1;
        b_upd_valid = 1'b0; b_upd_mis = 1'b0;
    endtask

    initial begin
        flush = 0; debug = 0; spec_valid = 0; spec_taken = 0;
        upd_valid = 0; upd_taken = 0; upd_mis = 0; upd_pc = '0; upd_hist = '0;
        vpc = 39'h1000;
        b_upd_valid = 0; b_upd_taken = 0; b_upd_mis = 0; b_upd_pc = '0; b_upd_hist = '0;
        b_vpc = '0;

        #1 rst_ni = 1'b0;
        #2;
        check("reset_valid", 32'(pv), 0);
        check("reset_taken", 32'(pt), 0);
        check("reset_hist",  32'(ph), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // First training pulse: prediction in the same cycle still shows the old entry
        upd_valid = 1'b1; upd_pc = 39'h1000; upd_hist = '0; upd_taken = 1'b1;
        #1 check("same_cycle_valid", 32'(pv), 0);
        @(posedge clk_i); #1;
        upd_valid = 1'b0;
        check("train1_valid", 32'(pv), 32'h1);
        check("train1_taken", 32'(pt), 32'h1);
        upd(39'h1000, 10'h0, 1'b1, 1'b0);
        upd(39'h1000, 10'h0, 1'b1, 1'b0);
        check("train3_valid", 32'(pv), 32'h1);
        check("train3_taken", 32'(pt), 32'h1);

        // Speculative shifts, then a mispredict that overrides a same-cycle shift
        spec(1'b1); spec(1'b1); spec(1'b0);
        check("spec_hist", 32'(ph), 32'h6);
        spec_valid = 1'b1; spec_taken = 1'b1;
        upd(39'h100, 10'h001, 1'b0, 1'b1);
        spec_valid = 1'b0;
        check("recover_hist", 32'(ph), 32'h2);

        // Flush wins over a same-cycle update
        flush = 1'b1;
        upd(39'h1004, 10'h0, 1'b1, 1'b0);
        flush = 1'b0;
        check("flush_hist", 32'(ph), 0);
        vpc = 39'h1000; #1;
        check("flush_valid_1000", 32'(pv), 0);
        vpc = 39'h1004; #1;
        check("flush_lost_upd", 32'(pv), 0);

        // Same PCs under different histories train separate entries
        upd(39'h1000, 10'h0, 1'b1, 1'b0);
        upd(39'h1000, 10'h0, 1'b1, 1'b0);
        upd(39'h1004, 10'h3, 1'b0, 1'b0);
        vpc = 39'h1000; #1;
        check("sep_g0_valid", 32'(pv), 32'h3);
        check("sep_g0_taken", 32'(pt), 32'h1);
        spec(1'b1); spec(1'b1);
        check("sep_hist", 32'(ph), 32'h3);
        vpc = 39'h1004; #1;
        check("sep_g3_valid", 32'(pv), 32'h3);
        check("sep_g3_taken", 32'(pt), 32'h2);
        vpc = 39'h1000; #1;
        check("sep_g3_untrained", 32'(pv), 0);

        // Debug mode: no training, no speculative shift, recovery still applies
        debug = 1'b1;
        upd(39'h1000, 10'h3, 1'b1, 1'b0);
        spec(1'b1);
        check("debug_hist_hold", 32'(ph), 32'h3);
        check("debug_no_train", 32'(pv), 0);
        upd(39'h1000, 10'h5, 1'b1, 1'b1);
        check("debug_recover", 32'(ph), 32'hB);
        debug = 1'b0;

        // Long history: GHR=0xA5FF at vpc=0 maps slot0 to 0x5A (folded) or 0xFF (truncated)
        b_upd(39'hB4,  16'h0,    1'b1, 1'b0);
        b_upd(39'h1FE, 16'h0,    1'b0, 1'b0);
        b_upd(39'h100, 16'h52FF, 1'b1, 1'b1);
        b_vpc = '0; #1;
        check("fold_hist", 32'(b_ph), 32'hA5FF);
        check("fold_valid", 32'(b_pv), 32'h1);
`ifdef GSHARE_HIST_FOLD_EN
        check("fold_taken", 32'(b_pt), 32'h1);
`else
        check("fold_taken", 32'(b_pt), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
